// File: rtl/kb_io_controller.sv
// MMIO front end for the keyboard ASCII buffer: sequences pops for CPU reads and
// for an autonomous echo sink, and exposes DATA/STATUS/CTRL/CMD plus a level irq.
module kb_io_controller #(
   parameter int DATA_W = 7,
   parameter int MMIO_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        mmio_addr,
   input  logic              mmio_rd,
   input  logic              mmio_wr,
   input  logic [MMIO_W-1:0] mmio_wdata,
   output logic [MMIO_W-1:0] mmio_rdata,
   output logic              mmio_ready,
   input  logic              kb_status,
   input  logic [DATA_W-1:0] kb_data,
   input  logic              kb_buf_full,
   output logic              kb_read_en,
   output logic              kb_clear,
   output logic              echo_valid,
   output logic [DATA_W-1:0] echo_data,
   input  logic              echo_ready,
   output logic              irq
);

   typedef enum logic [1:0] {IDLE, POP, CAPT, RESP} state_t;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_CTRL   = 2'd2;
   localparam logic [1:0] ADDR_CMD    = 2'd3;

   state_t            state;
   logic [1:0]        req_addr;
   logic              req_wr;
   logic [1:0]        req_bits;
   logic              drain;
   logic              echo_en;
   logic              irq_en;
   logic              new_flag;
   logic              overrun;
   logic [DATA_W-1:0] last_char;

   logic avail;
   logic req;
   logic cmd_wr;
   logic unused_bits;

   // In echo mode the CPU only sees characters the drain has already captured.
   assign avail       = echo_en ? new_flag : kb_status;
   assign req         = mmio_rd | mmio_wr;
   assign cmd_wr      = (state == RESP) && req_wr && (req_addr == ADDR_CMD);
   assign unused_bits = ^mmio_wdata[MMIO_W-1:2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         req_addr   <= '0;
         req_wr     <= 1'b0;
         req_bits   <= '0;
         drain      <= 1'b0;
         echo_en    <= 1'b0;
         irq_en     <= 1'b0;
         new_flag   <= 1'b0;
         overrun    <= 1'b0;
         last_char  <= '0;
         mmio_rdata <= '0;
         mmio_ready <= 1'b0;
         kb_read_en <= 1'b0;
         kb_clear   <= 1'b0;
         echo_valid <= 1'b0;
         echo_data  <= '0;
         irq        <= 1'b0;
      end else begin
         kb_read_en <= 1'b0;
         kb_clear   <= 1'b0;
         mmio_ready <= 1'b0;
         mmio_rdata <= '0;
         irq        <= irq_en & avail;

         // Sticky overrun: a full flag in the same cycle as a clear wins.
         if (kb_buf_full)
            overrun <= 1'b1;
         else if (cmd_wr && req_bits[1])
            overrun <= 1'b0;

         if (echo_valid && echo_ready)
            echo_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (req) begin
                  req_addr <= mmio_addr;
                  req_wr   <= mmio_wr;
                  req_bits <= mmio_wdata[1:0];
                  drain    <= 1'b0;
                  if (mmio_rd && mmio_addr == ADDR_DATA && !echo_en && kb_status) begin
                     state      <= POP;
                     kb_read_en <= 1'b1;
                  end else begin
                     state      <= RESP;
                     mmio_ready <= 1'b1;
                     if (mmio_rd) begin
                        case (mmio_addr)
                           ADDR_DATA: begin
                              if (echo_en) begin
                                 mmio_rdata <= MMIO_W'(last_char);
                                 new_flag   <= 1'b0;
                              end
                           end
                           ADDR_STATUS: mmio_rdata <= MMIO_W'({overrun, kb_buf_full, avail});
                           ADDR_CTRL:   mmio_rdata <= MMIO_W'({irq_en, echo_en});
                           default:     mmio_rdata <= '0;
                        endcase
                     end
                  end
               end else if (echo_en && kb_status && !echo_valid) begin
                  state      <= POP;
                  kb_read_en <= 1'b1;
                  drain      <= 1'b1;
               end
            end

            POP: state <= CAPT;

            // The buffer head is valid the cycle after the pop strobe.
            CAPT: begin
               if (drain) begin
                  echo_data  <= kb_data;
                  last_char  <= kb_data;
                  new_flag   <= 1'b1;
                  echo_valid <= 1'b1;
                  state      <= IDLE;
               end else begin
                  mmio_rdata <= MMIO_W'(kb_data);
                  mmio_ready <= 1'b1;
                  state      <= RESP;
               end
            end

            RESP: begin
               state <= IDLE;
               if (req_wr) begin
                  if (req_addr == ADDR_CTRL) begin
                     echo_en <= req_bits[0];
                     irq_en  <= req_bits[1];
                  end else if (req_addr == ADDR_CMD && req_bits[0]) begin
                     kb_clear   <= 1'b1;
                     new_flag   <= 1'b0;
                     echo_valid <= 1'b0;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_kb_io_controller.sv
// Directed and randomized bench for kb_io_controller with a queue-based keyboard
// buffer model and a scoreboard of expected CPU read data and echoed characters.
module tb_kb_io_controller;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] mmio_addr = 2'd0;
   logic       mmio_rd = 1'b0;
   logic       mmio_wr = 1'b0;
   logic [7:0] mmio_wdata = 8'h00;
   logic [7:0] mmio_rdata;
   logic       mmio_ready;
   logic       kb_status = 1'b0;
   logic [6:0] kb_data = 7'h00;
   logic       kb_buf_full = 1'b0;
   logic       kb_read_en;
   logic       kb_clear;
   logic       echo_valid;
   logic [6:0] echo_data;
   logic       echo_ready = 1'b0;
   logic       irq;

   kb_io_controller #(.DATA_W(7), .MMIO_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .mmio_addr(mmio_addr), .mmio_rd(mmio_rd), .mmio_wr(mmio_wr),
      .mmio_wdata(mmio_wdata), .mmio_rdata(mmio_rdata), .mmio_ready(mmio_ready),
      .kb_status(kb_status), .kb_data(kb_data), .kb_buf_full(kb_buf_full),
      .kb_read_en(kb_read_en), .kb_clear(kb_clear),
      .echo_valid(echo_valid), .echo_data(echo_data), .echo_ready(echo_ready),
      .irq(irq)
   );

   always #5 clk = ~clk;

   logic [6:0] kbq[$];
   logic [6:0] echo_log[$];
   int tests = 0;
   int fails = 0;
   int pops = 0;
   int clears = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample strobes mid-cycle, then update the buffer model after the edge.
   task automatic tick();
      logic rd_s, hs_s, clr_s;
      logic [6:0] ed_s;
      @(negedge clk);
      rd_s  = kb_read_en;
      hs_s  = echo_valid & echo_ready;
      ed_s  = echo_data;
      clr_s = kb_clear;
      @(posedge clk);
      #1;
      if (rd_s) begin
         pops++;
         if (kbq.size() > 0) kb_data = kbq.pop_front();
         else kb_data = 7'h7f;
      end
      if (hs_s) echo_log.push_back(ed_s);
      if (clr_s) clears++;
      kb_status = (kbq.size() != 0);
   endtask

   task automatic push(input logic [6:0] c);
      kbq.push_back(c);
      kb_status = 1'b1;
   endtask

   task automatic mmio(input logic wr, input logic [1:0] addr, input logic [7:0] wdata,
                       output logic [7:0] rdata, output int lat);
      mmio_addr  = addr;
      mmio_wr    = wr;
      mmio_rd    = !wr;
      mmio_wdata = wdata;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!mmio_ready && lat < 20);
      rdata   = mmio_rdata;
      mmio_rd = 1'b0;
      mmio_wr = 1'b0;
      tick();
   endtask

   initial begin
      logic [7:0] rd;
      int lat, pbase, cbase, ebase, n;
      logic [6:0] c, exp_c;
      logic ov_m;
      logic [6:0] exp_echo[$];

      // Reset state
      repeat (3) tick();
      chk("rst_ctl", 32'({mmio_ready, kb_read_en, kb_clear, echo_valid, irq}), 32'h0);
      chk("rst_data", 32'({mmio_rdata, 1'b0, echo_data}), 32'h0);
      rst_n = 1'b1;
      tick();

      // CPU read with a character waiting
      push(7'h41);
      pbase = pops;
      mmio(1'b0, 2'd0, 8'h00, rd, lat);
      chk("rd_char", 32'(rd), 32'h41);
      chk("rd_char_lat", 32'(lat), 32'd3);
      chk("rd_char_pops", 32'(pops - pbase), 32'd1);

      // CPU read with an empty buffer
      pbase = pops;
      mmio(1'b0, 2'd0, 8'h00, rd, lat);
      chk("rd_empty", 32'(rd), 32'h00);
      chk("rd_empty_lat", 32'(lat), 32'd1);
      chk("rd_empty_pops", 32'(pops - pbase), 32'd0);
      mmio(1'b0, 2'd1, 8'h00, rd, lat);
      chk("status_idle", 32'(rd), 32'h00);

      // Echo mode with interrupts, sink stalled
      mmio(1'b1, 2'd2, 8'hff, rd, lat);
      chk("wr_lat", 32'(lat), 32'd1);
      mmio(1'b0, 2'd2, 8'h00, rd, lat);
      chk("ctrl_rb", 32'(rd), 32'h03);
      echo_ready = 1'b0;
      pbase = pops;
      push(7'h62);
      repeat (5) tick();
      chk("echo_pop", 32'(pops - pbase), 32'd1);
      chk("echo_valid", 32'(echo_valid), 32'd1);
      chk("echo_data", 32'(echo_data), 32'h62);
      chk("irq_on", 32'(irq), 32'd1);
      push(7'h63);
      repeat (4) tick();
      chk("echo_backpressure", 32'(pops - pbase), 32'd1);
      mmio(1'b0, 2'd1, 8'h00, rd, lat);
      chk("status_new", 32'(rd), 32'h01);
      mmio(1'b0, 2'd0, 8'h00, rd, lat);
      chk("echo_rd", 32'(rd), 32'h62);
      chk("echo_rd_lat", 32'(lat), 32'd1);
      chk("irq_off", 32'(irq), 32'd0);
      echo_ready = 1'b1;
      tick();
      chk("echo_drop", 32'(echo_valid), 32'd0);
      chk("echo_log1", 32'(echo_log.size()), 32'd1);
      repeat (5) tick();
      chk("echo_log2", 32'(echo_log.size()), 32'd2);
      chk("echo_second", 32'(echo_log[1]), 32'h63);
      mmio(1'b0, 2'd0, 8'h00, rd, lat);
      chk("echo_rd2", 32'(rd), 32'h63);

      // MMIO beats a drain arriving in the same cycle
      mmio_addr = 2'd1;
      mmio_rd = 1'b1;
      push(7'h35);
      tick();
      chk("arb_ready", 32'(mmio_ready), 32'd1);
      chk("arb_status", 32'(mmio_rdata), 32'h00);
      chk("arb_nopop", 32'(kb_read_en), 32'd0);
      mmio_rd = 1'b0;
      tick();
      chk("arb_resp_nopop", 32'(kb_read_en), 32'd0);
      tick();
      chk("arb_drain_pop", 32'(kb_read_en), 32'd1);
      repeat (4) tick();
      chk("arb_echo", 32'(echo_log[echo_log.size()-1]), 32'h35);

      // Overrun and CMD
      mmio(1'b1, 2'd2, 8'h00, rd, lat);
      kb_buf_full = 1'b1;
      tick();
      kb_buf_full = 1'b0;
      mmio(1'b0, 2'd1, 8'h00, rd, lat);
      chk("ovr_set", 32'(rd), 32'h04);
      mmio(1'b1, 2'd3, 8'h02, rd, lat);
      mmio(1'b0, 2'd1, 8'h00, rd, lat);
      chk("ovr_clr", 32'(rd), 32'h00);
      kb_buf_full = 1'b1;
      mmio(1'b1, 2'd3, 8'h02, rd, lat);
      kb_buf_full = 1'b0;
      mmio(1'b0, 2'd1, 8'h00, rd, lat);
      chk("ovr_set_wins", 32'(rd), 32'h04);
      mmio(1'b1, 2'd3, 8'h02, rd, lat);
      cbase = clears;
      mmio(1'b1, 2'd3, 8'h01, rd, lat);
      repeat (3) tick();
      chk("clear_pulse", 32'(clears - cbase), 32'd1);

      // CMD clear drops a stalled echo; disabling echo leaves a pending one alone
      mmio(1'b1, 2'd2, 8'h01, rd, lat);
      echo_ready = 1'b0;
      ebase = echo_log.size();
      push(7'h55);
      repeat (5) tick();
      chk("cmd_echo_pre", 32'({echo_valid, echo_data}), 32'({1'b1, 7'h55}));
      mmio(1'b1, 2'd3, 8'h01, rd, lat);
      chk("cmd_echo_drop", 32'(echo_valid), 32'd0);
      mmio(1'b0, 2'd1, 8'h00, rd, lat);
      chk("cmd_newflag", 32'(rd), 32'h00);
      push(7'h56);
      repeat (5) tick();
      mmio(1'b1, 2'd2, 8'h00, rd, lat);
      chk("echo_kept", 32'({echo_valid, echo_data}), 32'({1'b1, 7'h56}));
      echo_ready = 1'b1;
      tick();
      chk("echo_kept_done", 32'(echo_valid), 32'd0);
      chk("echo_kept_log", 32'(echo_log.size() - ebase), 32'd1);

      // Reset during the pop of a CPU read
      push(7'h77);
      mmio_addr = 2'd0;
      mmio_rd = 1'b1;
      tick();
      chk("pre_rst_pop", 32'(kb_read_en), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_async", 32'({mmio_ready, kb_read_en, kb_clear, echo_valid, irq, mmio_rdata}), 32'h0);
      mmio_rd = 1'b0;
      tick();
      rst_n = 1'b1;
      n = 0;
      repeat (4) begin
         tick();
         if (mmio_ready) n++;
      end
      chk("rst_no_ready", 32'(n), 32'd0);
      mmio(1'b0, 2'd0, 8'h00, rd, lat);
      chk("post_rst_rd", 32'(rd), 32'h77);
      chk("post_rst_lat", 32'(lat), 32'd3);

      // Randomized CPU traffic, echo disabled
      ov_m = 1'b0;
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 4))
            0: begin
               c = 7'($urandom_range(0, 127));
               push(c);
               if ($urandom_range(0, 1) == 1) push(7'($urandom_range(0, 127)));
            end
            1, 2: begin
               exp_c = (kbq.size() != 0) ? kbq[0] : 7'h00;
               n = (kbq.size() != 0) ? 1 : 0;
               pbase = pops;
               mmio(1'b0, 2'd0, 8'h00, rd, lat);
               chk("rnd_data", 32'(rd), 32'(exp_c));
               chk("rnd_lat", 32'(lat), (n == 1) ? 32'd3 : 32'd1);
               chk("rnd_pops", 32'(pops - pbase), 32'(n));
            end
            3: begin
               kb_buf_full = 1'b1;
               tick();
               kb_buf_full = 1'b0;
               ov_m = 1'b1;
            end
            default: begin
               if ($urandom_range(0, 1) == 1) begin
                  mmio(1'b1, 2'd3, 8'h02, rd, lat);
                  ov_m = 1'b0;
               end
               mmio(1'b0, 2'd1, 8'h00, rd, lat);
               chk("rnd_status", 32'(rd), 32'({ov_m, 1'b0, kbq.size() != 0}));
            end
         endcase
      end

      // Randomized echo drain with a jittery sink
      while (kbq.size() != 0) begin
         mmio(1'b0, 2'd0, 8'h00, rd, lat);
      end
      mmio(1'b1, 2'd2, 8'h01, rd, lat);
      ebase = echo_log.size();
      for (int i = 0; i < 80; i++) begin
         echo_ready = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 3) == 0) begin
            c = 7'($urandom_range(0, 127));
            push(c);
            exp_echo.push_back(c);
         end
         tick();
      end
      echo_ready = 1'b1;
      n = 0;
      while (echo_log.size() < ebase + exp_echo.size() && n < 400) begin
         tick();
         n++;
      end
      chk("rnd_echo_count", 32'(echo_log.size() - ebase), 32'(exp_echo.size()));
      for (int i = 0; i < exp_echo.size(); i++) begin
         if (ebase + i < echo_log.size())
            chk("rnd_echo_seq", 32'(echo_log[ebase + i]), 32'(exp_echo[i]));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/kb_io_controller.md
Name: kb_io_controller

Overview:
- Memory-mapped I/O controller between the Y86 CPU data-memory port and the keyboard interface (ASCII buffer with pop/clear/status).
- Sequences buffer pops, captures characters, and exposes DATA/STATUS/CTRL/CMD registers.
- Shares the buffer between two requesters: CPU reads and an optional autonomous echo sink (console/display).
- Generates a level interrupt when a character is available.

Parameters:
- DATA_W, 7, ASCII character width from the keyboard buffer.
- MMIO_W, 8, MMIO data bus width; characters are zero-extended to this width.

Ports:
- clk  in  1  master clock
- rst_n  in  1  asynchronous active-low reset
- mmio_addr  in  2  register select: 0 DATA, 1 STATUS, 2 CTRL, 3 CMD
- mmio_rd  in  1  read request; held until mmio_ready
- mmio_wr  in  1  write request; held until mmio_ready
- mmio_wdata  in  MMIO_W  write data
- mmio_rdata  out  MMIO_W  read data; valid while mmio_ready=1
- mmio_ready  out  1  one-cycle completion strobe
- kb_status  in  1  keyboard buffer non-empty
- kb_data  in  DATA_W  buffer head; valid the cycle after a kb_read_en pulse
- kb_buf_full  in  1  keyboard buffer full
- kb_read_en  out  1  one-cycle pop strobe
- kb_clear  out  1  one-cycle flush strobe
- echo_valid  out  1  echo character valid
- echo_data  out  DATA_W  echo character
- echo_ready  in  1  echo sink accepts the character when echo_valid & echo_ready
- irq  out  1  interrupt, registered

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE. All outputs 0. Registers CTRL, last_char, new_flag and overrun are 0. Asserting reset mid-operation aborts it; no completion is issued.
- Registers:
  - CTRL: bit0 echo_en, bit1 irq_en; other bits read 0.
  - STATUS read: {5'b0, overrun, kb_buf_full, avail}, where avail = echo_en ? new_flag : kb_status.
  - CMD write: bit0 issues a kb_clear pulse and clears new_flag and echo_valid; bit1 clears overrun.
  - DATA write: ignored, completes normally.
- FSM states: IDLE, POP, CAPT, RESP.
  - MMIO requests are accepted only in IDLE; mmio_rd and mmio_wr are never asserted together.
- CPU DATA read, echo_en=0, kb_status=1: IDLE -> POP (kb_read_en=1) -> CAPT (latch kb_data) -> RESP (mmio_ready=1, rdata = zero-extended char) -> IDLE. mmio_ready is asserted 3 cycles after acceptance.
- CPU DATA read, echo_en=0, kb_status=0: IDLE -> RESP, rdata=0x00, no pop.
- CPU DATA read, echo_en=1: IDLE -> RESP, rdata=last_char, new_flag cleared, no pop.
- Other register accesses (STATUS/CTRL/CMD, any DATA write): IDLE -> RESP (1-cycle latency). Writes take effect at the RESP edge.
- Echo drain (autonomous pop):
  - Condition in IDLE: echo_en=1, kb_status=1, echo_valid=0, and no MMIO request present.
  - Sequence: IDLE -> POP -> CAPT. At CAPT, echo_data, last_char and new_flag are loaded and echo_valid=1. Return to IDLE without mmio_ready.
  - echo_valid holds until echo_ready is sampled 1, then drops the next cycle.
- Arbitration: fixed priority, an MMIO request beats the echo drain in IDLE. The drain cannot start while echo_valid=1, so the echo sink backpressures pops.
- Simultaneous events:
  - An MMIO request arriving during an echo POP/CAPT waits until IDLE.
  - A CMD clear while echo_valid=1 drops echo_valid at the RESP edge, regardless of echo_ready.
  - Clearing echo_en while echo_valid=1 leaves the pending echo to complete normally.
- overrun: set (sticky) on any cycle with kb_buf_full=1; cleared only by CMD bit1. If set and clear coincide, set wins.
- irq: registered from irq_en & avail, so it rises 1 cycle after the condition.
- new_flag: set and cleared in the same cycle (CAPT vs RESP) is impossible because the FSM is single-threaded.

Test Plan:
- Reset, then kb_status=1 with kb_data=0x41; CPU reads addr0 with echo_en=0 -> one kb_read_en pulse; mmio_ready 3 cycles after request with rdata=0x41.
- kb_status=0, CPU reads addr0 -> mmio_ready the next cycle, rdata=0x00, kb_read_en never asserted.
- Write CTRL=0x03, then kb_status=1 with data 0x62, echo_ready=0 -> single pop, echo_valid=1 with echo_data=0x62, no second pop. irq=1. A DATA read returns 0x62 and irq drops. Then echo_ready=1 -> echo_valid falls.
- Echo mode: assert mmio_rd (STATUS) in the same cycle kb_status rises -> MMIO served first (ready after 1 cycle), echo pop starts on the following IDLE cycle.
- kb_buf_full pulsed for 1 cycle -> STATUS bit2=1 persists. Write CMD=0x02 -> bit2=0. Write CMD=0x01 -> kb_clear pulse exactly 1 cycle.
- Assert rst_n=0 during POP of a CPU read -> all outputs 0 immediately, no mmio_ready issued; the next read completes normally.
